rs_bank: RTL and testbench
==========================

# rs_bank

Reservation-station bank for the dual-issue Tomasulo core. It allocates entries and issue tags for up to two instructions per cycle (ports A and B, A older). The tags go to the register file as rd_tag_A/B, and the bank takes that file's renamed operands (value or tag). Pending operands are resolved by snooping the CDB, and one ready entry per cycle is dispatched to the attached functional unit over a valid/ready handshake.

## Interface
- DEPTH, 4: number of entries, 2..8.
- RS_ID, 1: 5-bit bank ID, nonzero; forms the upper tag bits.
- Tag format: {RS_ID[4:0], entry_index[2:0]}. Tags are never 8'd0, because 8'd0 means "no tag / no broadcast" system-wide.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alloc_req_A, alloc_req_B  in  1  issue request per port.
- op_A, op_B  in  4  opcode, stored opaque.
- opnd1_A, opnd2_A, opnd1_B, opnd2_B  in  32  operands from the register file. A tag occupies bits [7:0].
- type1_A, type2_A, type1_B, type2_B  in  1  operand type: 0 = value, 1 = tag.
- alloc_gnt_A, alloc_gnt_B  out  1  combinational grant. These drive the register-file instr_valid_A/B.
- tag_A, tag_B  out  8  combinational tag of the granted entry; 8'd0 when not granted.
- data_in_CDB  in  32  CDB result.
- tag_in_CDB  in  8  CDB tag; 8'd0 means idle.
- disp_valid  out  1  an entry is ready to execute.
- disp_ready  in  1  functional unit accepts.
- disp_op  out  4  opcode of the dispatched entry.
- disp_a, disp_b  out  32  operand values of the dispatched entry.
- disp_tag  out  8  tag of the dispatched entry; the FU returns it on the CDB.
- busy_count  out  4  number of occupied entries.

## Operation
- Per-entry state: busy, op, val1/val2, pend1/pend2, qtag1/qtag2.
- Grant rules:
  - Free entries are counted combinationally.
  - The oldest requesting port gets the lowest free index. The younger port gets the next lowest free index.
  - B is never granted unless A is granted or A is not requesting, so issue stays in order.
  - If only one entry is free and both ports request, only A is granted.
  - An entry freed by dispatch in the same cycle does not count as free until the next cycle.
- Allocation write (posedge, per granted port):
  - Set busy and store op.
  - Per operand: if type=0, store the value and clear pend.
  - If type=1 and opnd[7:0]==tag_in_CDB, capture data_in_CDB and clear pend. This same-cycle bypass is required because the register file does not forward the CDB.
  - Otherwise set pend and qtag=opnd[7:0].
- CDB snoop (posedge): every busy entry with pendN && qtagN==tag_in_CDB && tag_in_CDB!=0 loads valN=data_in_CDB and clears pendN. Both operands may resolve in the same cycle.
- Ready condition: busy && !pend1 && !pend2, evaluated on registered state only.
- Dispatch:
  - disp_valid = any ready entry. The lowest ready index is selected.
  - The disp_* outputs are combinational from the selected entry.
  - When disp_valid && disp_ready, the selected entry's busy is cleared at the posedge.
  - While disp_valid is high and disp_ready is low, the selection must not change unless a lower index becomes ready.
  - The disp_* outputs are 0 when disp_valid=0.
- busy_count is the registered popcount of busy.

## Timing
- Reset: all busy/pend cleared, val/qtag zeroed. After reset: disp_valid=0, disp_* =0, busy_count=0.
- While reset is high, alloc_gnt_A/B=0 and tag_A/B=0.
- Reset asserted mid-operation discards all entries on that edge.
- Latency from allocation with value operands to disp_valid: 1 cycle.
- Latency from a CDB broadcast resolving the last pending operand to disp_valid: 1 cycle.
- No dispatch happens in the same cycle as the resolving broadcast.
- Full: busy_count==DEPTH forces alloc_gnt_A=alloc_gnt_B=0.
- Simultaneous allocation, CDB snoop and dispatch in one cycle are all legal and act on distinct entries.
- A CDB tag matching no pending operand has no effect.

## Test plan
- Reset, then A issues op=3 with opnd1=5 and opnd2=7 (both type 0):
  - gnt_A=1, tag_A=8'h08.
  - Next cycle: disp_valid=1, disp_a=5, disp_b=7, disp_tag=8'h08.
  - disp_ready=1 returns busy_count to 0.
- A issues with opnd1 = tag 8'h11 (type 1):
  - No dispatch occurs.
  - A CDB broadcast tag 8'h11 with data 32'hDEAD gives disp_valid=1 one cycle later, with disp_a=32'hDEAD.
- Same-cycle bypass:
  - Allocate an operand of tag 8'h11 while tag_in_CDB=8'h11 and data=9.
  - The entry is ready the next cycle with value 9.
- DEPTH=4, three entries busy, both ports request:
  - gnt_A=1, gnt_B=0, tag_B=0.
  - Next cycle (full): both grants are 0.
- Dual issue into an empty bank:
  - tag_A=8'h08, tag_B=8'h09.
  - With both entries ready, entry 0 dispatches first.
  - If disp_ready is held low for 3 cycles, disp_tag stays 8'h08.
- Assert reset with 3 busy entries and pending tags:
  - busy_count=0 and disp_valid=0 on the next cycle.
  - A later CDB broadcast of an old tag does not set disp_valid.

Source files
------------

// File: rtl/rs_bank.sv
// -----------------------------------------------------------------------------
// rs_bank -- reservation-station bank for the dual-issue Tomasulo core.
//
// Allocates up to two entries per cycle (port A older than port B), holds the
// renamed operands, resolves pending operands by snooping the CDB and hands
// one ready entry per cycle to the functional unit over valid/ready.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   alloc_req_A/B               issue request per port
//   op_A/B                      opcode, stored opaque
//   opnd1/2_A/B, type1/2_A/B    renamed operands (type 0 = value, 1 = tag in [7:0])
//   alloc_gnt_A/B               combinational grant (register-file instr_valid)
//   tag_A/B                     tag of the granted entry, 0 when not granted
//   data_in_CDB, tag_in_CDB     CDB broadcast (tag 0 = idle)
//   disp_valid, disp_ready      dispatch handshake
//   disp_op, disp_a, disp_b     payload of the selected entry (0 when idle)
//   disp_tag                    tag of the selected entry
//   busy_count                  registered number of occupied entries
//
// Tag format is {RS_ID, entry_index}; RS_ID is nonzero, so no tag is ever 0.
// -----------------------------------------------------------------------------
module rs_bank #(
   parameter int         DEPTH = 4,
   parameter logic [4:0] RS_ID = 5'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alloc_req_A,
   input  logic        alloc_req_B,
   input  logic [3:0]  op_A,
   input  logic [3:0]  op_B,
   input  logic [31:0] opnd1_A,
   input  logic [31:0] opnd2_A,
   input  logic [31:0] opnd1_B,
   input  logic [31:0] opnd2_B,
   input  logic        type1_A,
   input  logic        type2_A,
   input  logic        type1_B,
   input  logic        type2_B,
   output logic        alloc_gnt_A,
   output logic        alloc_gnt_B,
   output logic [7:0]  tag_A,
   output logic [7:0]  tag_B,
   input  logic [31:0] data_in_CDB,
   input  logic [7:0]  tag_in_CDB,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic [3:0]  disp_op,
   output logic [31:0] disp_a,
   output logic [31:0] disp_b,
   output logic [7:0]  disp_tag,
   output logic [3:0]  busy_count
);

   localparam logic [3:0] DEPTH_W = 4'(DEPTH);

   // Resolved form of one incoming operand.
   typedef struct packed {
      logic        pend;
      logic [7:0]  qtag;
      logic [31:0] val;
   } opnd_t;

   // A tag operand that matches the CDB in the allocation cycle is captured
   // directly, because the register file does not forward the CDB itself.
   function automatic opnd_t resolve_opnd(input logic [31:0] opnd,
                                          input logic        typ,
                                          input logic [7:0]  cdb_tag,
                                          input logic [31:0] cdb_data);
      opnd_t r;
      r.pend = 1'b0;
      r.qtag = 8'd0;
      r.val  = 32'd0;
      if (!typ) begin
         r.val = opnd;
      end else if (cdb_tag != 8'd0 && opnd[7:0] == cdb_tag) begin
         r.val = cdb_data;
      end else begin
         r.pend = 1'b1;
         r.qtag = opnd[7:0];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   logic        busy_reg  [DEPTH];
   logic        pend1_reg [DEPTH];
   logic        pend2_reg [DEPTH];
   logic [3:0]  op_reg    [DEPTH];
   logic [31:0] val1_reg  [DEPTH];
   logic [31:0] val2_reg  [DEPTH];
   logic [7:0]  qtag1_reg [DEPTH];
   logic [7:0]  qtag2_reg [DEPTH];
   logic [3:0]  busy_count_reg;

   // ---------------------------------------------------------------- per-entry vectors
   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] sel_a_vec;
   logic [DEPTH-1:0] sel_b_vec;
   logic [DEPTH-1:0] disp_clr_vec;
   logic [DEPTH-1:0] hit1_vec;
   logic [DEPTH-1:0] hit2_vec;
   logic [DEPTH-1:0] busy_next;

   logic       gnt_a, gnt_b;
   logic [2:0] idx_a, idx_b;
   logic       disp_found;
   logic [2:0] disp_idx;
   logic       disp_fire;
   logic [3:0] busy_count_next;

   opnd_t res_a1, res_a2, res_b1, res_b2;

   assign res_a1 = resolve_opnd(opnd1_A, type1_A, tag_in_CDB, data_in_CDB);
   assign res_a2 = resolve_opnd(opnd2_A, type2_A, tag_in_CDB, data_in_CDB);
   assign res_b1 = resolve_opnd(opnd1_B, type1_B, tag_in_CDB, data_in_CDB);
   assign res_b2 = resolve_opnd(opnd2_B, type2_B, tag_in_CDB, data_in_CDB);

   assign disp_fire = disp_found & disp_ready;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
         // Freeness uses registered busy only, so a slot vacated by this
         // cycle's dispatch is not reused until the next cycle.
         assign free_vec[gi]     = ~busy_reg[gi];
         assign ready_vec[gi]    = busy_reg[gi] & ~pend1_reg[gi] & ~pend2_reg[gi];
         assign sel_a_vec[gi]    = gnt_a && (idx_a == 3'(gi));
         assign sel_b_vec[gi]    = gnt_b && (idx_b == 3'(gi));
         assign disp_clr_vec[gi] = disp_fire && (disp_idx == 3'(gi));
         assign hit1_vec[gi]     = busy_reg[gi] && pend1_reg[gi] &&
                                   (tag_in_CDB != 8'd0) && (qtag1_reg[gi] == tag_in_CDB);
         assign hit2_vec[gi]     = busy_reg[gi] && pend2_reg[gi] &&
                                   (tag_in_CDB != 8'd0) && (qtag2_reg[gi] == tag_in_CDB);
         assign busy_next[gi]    = (busy_reg[gi] & ~disp_clr_vec[gi]) |
                                   sel_a_vec[gi] | sel_b_vec[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- grant
   always_comb begin
      logic       f0_found, f1_found;
      logic [2:0] f0_idx, f1_idx;
      f0_found = 1'b0;
      f1_found = 1'b0;
      f0_idx   = 3'd0;
      f1_idx   = 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (free_vec[i]) begin
            if (!f0_found) begin
               f0_found = 1'b1;
               f0_idx   = 3'(i);
            end else if (!f1_found) begin
               f1_found = 1'b1;
               f1_idx   = 3'(i);
            end
         end
      end

      gnt_a = 1'b0;
      gnt_b = 1'b0;
      idx_a = 3'd0;
      idx_b = 3'd0;
      if (!reset && busy_count_reg != DEPTH_W) begin
         if (alloc_req_A) begin
            // B only follows a granted A, keeping issue in program order.
            gnt_a = f0_found;
            idx_a = f0_idx;
            gnt_b = alloc_req_B && f0_found && f1_found;
            idx_b = f1_idx;
         end else begin
            gnt_b = alloc_req_B && f0_found;
            idx_b = f0_idx;
         end
      end
   end

   assign alloc_gnt_A = gnt_a;
   assign alloc_gnt_B = gnt_b;
   assign tag_A       = gnt_a ? {RS_ID, idx_a} : 8'd0;
   assign tag_B       = gnt_b ? {RS_ID, idx_b} : 8'd0;

   // ---------------------------------------------------------------- dispatch select
   // Lowest ready index wins. Ready entries stay ready until dispatched, so
   // the choice is stable while stalled unless a lower entry becomes ready.
   always_comb begin
      disp_found = 1'b0;
      disp_idx   = 3'd0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            disp_found = 1'b1;
            disp_idx   = 3'(i);
         end
      end
   end

   always_comb begin
      disp_op  = 4'd0;
      disp_a   = 32'd0;
      disp_b   = 32'd0;
      disp_tag = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_found && disp_idx == 3'(i)) begin
            disp_op  = op_reg[i];
            disp_a   = val1_reg[i];
            disp_b   = val2_reg[i];
            disp_tag = {RS_ID, 3'(i)};
         end
      end
   end

   assign disp_valid = disp_found;

   // ---------------------------------------------------------------- occupancy
   always_comb begin
      busy_count_next = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_count_next = busy_count_next + {3'd0, busy_next[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_count_reg <= 4'd0;
      end else begin
         busy_count_reg <= busy_count_next;
      end
   end

   assign busy_count = busy_count_reg;

   // ---------------------------------------------------------------- entry update
   // Allocation only targets free entries, snoop only pending ones and
   // dispatch only ready ones, so the three never touch the same entry.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (reset) begin
               busy_reg[gi]  <= 1'b0;
               pend1_reg[gi] <= 1'b0;
               pend2_reg[gi] <= 1'b0;
               op_reg[gi]    <= 4'd0;
               val1_reg[gi]  <= 32'd0;
               val2_reg[gi]  <= 32'd0;
               qtag1_reg[gi] <= 8'd0;
               qtag2_reg[gi] <= 8'd0;
            end else begin
               busy_reg[gi] <= busy_next[gi];
               if (sel_a_vec[gi]) begin
                  op_reg[gi]    <= op_A;
                  val1_reg[gi]  <= res_a1.val;
                  pend1_reg[gi] <= res_a1.pend;
                  qtag1_reg[gi] <= res_a1.qtag;
                  val2_reg[gi]  <= res_a2.val;
                  pend2_reg[gi] <= res_a2.pend;
                  qtag2_reg[gi] <= res_a2.qtag;
               end else if (sel_b_vec[gi]) begin
                  op_reg[gi]    <= op_B;
                  val1_reg[gi]  <= res_b1.val;
                  pend1_reg[gi] <= res_b1.pend;
                  qtag1_reg[gi] <= res_b1.qtag;
                  val2_reg[gi]  <= res_b2.val;
                  pend2_reg[gi] <= res_b2.pend;
                  qtag2_reg[gi] <= res_b2.qtag;
               end else begin
                  if (hit1_vec[gi]) begin
                     val1_reg[gi]  <= data_in_CDB;
                     pend1_reg[gi] <= 1'b0;
                  end
                  if (hit2_vec[gi]) begin
                     val2_reg[gi]  <= data_in_CDB;
                     pend2_reg[gi] <= 1'b0;
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_rs_bank.sv
// -----------------------------------------------------------------------------
// tb_rs_bank -- self-checking bench for rs_bank (DEPTH=4, RS_ID=1).
// Directed vector table, a hand-written corner sequence, then randomized
// traffic checked against a behavioural model of the reservation station.
// -----------------------------------------------------------------------------
module tb_rs_bank;

   localparam int DEPTH = 4;
   localparam int RS_ID = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_req_A, alloc_req_B;
   logic [3:0]  op_A, op_B;
   logic [31:0] opnd1_A, opnd2_A, opnd1_B, opnd2_B;
   logic        type1_A, type2_A, type1_B, type2_B;
   logic        alloc_gnt_A, alloc_gnt_B;
   logic [7:0]  tag_A, tag_B;
   logic [31:0] data_in_CDB;
   logic [7:0]  tag_in_CDB;
   logic        disp_valid, disp_ready;
   logic [3:0]  disp_op;
   logic [31:0] disp_a, disp_b;
   logic [7:0]  disp_tag;
   logic [3:0]  busy_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rs_bank #(.DEPTH(DEPTH), .RS_ID(5'd1)) dut (
      .clk(clk), .reset(reset),
      .alloc_req_A(alloc_req_A), .alloc_req_B(alloc_req_B),
      .op_A(op_A), .op_B(op_B),
      .opnd1_A(opnd1_A), .opnd2_A(opnd2_A), .opnd1_B(opnd1_B), .opnd2_B(opnd2_B),
      .type1_A(type1_A), .type2_A(type2_A), .type1_B(type1_B), .type2_B(type2_B),
      .alloc_gnt_A(alloc_gnt_A), .alloc_gnt_B(alloc_gnt_B),
      .tag_A(tag_A), .tag_B(tag_B),
      .data_in_CDB(data_in_CDB), .tag_in_CDB(tag_in_CDB),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_op(disp_op), .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag),
      .busy_count(busy_count)
   );

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge; outputs settle #1 later.
   task automatic drive(input logic rst, input logic ra, input logic rb,
                        input logic [3:0] opa, input logic [31:0] o1a, input logic [31:0] o2a,
                        input logic t1a, input logic t2a,
                        input logic [3:0] opb, input logic [31:0] o1b, input logic [31:0] o2b,
                        input logic t1b, input logic t2b,
                        input logic [7:0] ct, input logic [31:0] cd, input logic rdy);
      @(negedge clk);
      reset = rst; alloc_req_A = ra; alloc_req_B = rb;
      op_A = opa; opnd1_A = o1a; opnd2_A = o2a; type1_A = t1a; type2_A = t2a;
      op_B = opb; opnd1_B = o1b; opnd2_B = o2b; type1_B = t1b; type2_B = t2b;
      tag_in_CDB = ct; data_in_CDB = cd; disp_ready = rdy;
      #1;
   endtask

   task automatic idle(input logic rst, input logic [7:0] ct, input logic [31:0] cd, input logic rdy);
      drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ct, cd, rdy);
   endtask

   task automatic check_outs(input string p, input logic ga, input logic [7:0] ta,
                             input logic gb, input logic [7:0] tb, input logic dv,
                             input logic [3:0] dop, input logic [31:0] da, input logic [31:0] db,
                             input logic [7:0] dt, input logic [3:0] bc);
      chk({p, ".gnt_A"}, 32'(alloc_gnt_A), 32'(ga));
      chk({p, ".tag_A"}, 32'(tag_A), 32'(ta));
      chk({p, ".gnt_B"}, 32'(alloc_gnt_B), 32'(gb));
      chk({p, ".tag_B"}, 32'(tag_B), 32'(tb));
      chk({p, ".disp_valid"}, 32'(disp_valid), 32'(dv));
      chk({p, ".disp_op"}, 32'(disp_op), 32'(dop));
      chk({p, ".disp_a"}, disp_a, da);
      chk({p, ".disp_b"}, disp_b, db);
      chk({p, ".disp_tag"}, 32'(disp_tag), 32'(dt));
      chk({p, ".busy_count"}, 32'(busy_count), 32'(bc));
   endtask

   // ---------------------------------------------------------------- vector table
   // A uses op 3 with type2=0; B uses op 5 with values 0x100/0x200.
   typedef struct {
      logic        rst, ra, rb, t1;
      logic [31:0] o1, o2;
      logic [7:0]  ct;
      logic [31:0] cd;
      logic        rdy;
      logic        ga;
      logic [7:0]  ta;
      logic        gb;
      logic [7:0]  tb;
      logic        dv;
      logic [3:0]  dop;
      logic [31:0] da, db;
      logic [7:0]  dt;
      logic [3:0]  bc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic ra, input logic rb, input logic t1,
                      input logic [31:0] o1, input logic [31:0] o2,
                      input logic [7:0] ct, input logic [31:0] cd, input logic rdy,
                      input logic ga, input logic [7:0] ta, input logic gb, input logic [7:0] tb,
                      input logic dv, input logic [3:0] dop, input logic [31:0] da,
                      input logic [31:0] db, input logic [7:0] dt, input logic [3:0] bc);
      vec_t v;
      v.rst = rst; v.ra = ra; v.rb = rb; v.t1 = t1; v.o1 = o1; v.o2 = o2;
      v.ct = ct; v.cd = cd; v.rdy = rdy; v.ga = ga; v.ta = ta; v.gb = gb; v.tb = tb;
      v.dv = dv; v.dop = dop; v.da = da; v.db = db; v.dt = dt; v.bc = bc;
      tbl.push_back(v);
   endtask

   // ---------------------------------------------------------------- reference model
   logic        m_busy [DEPTH];
   logic        m_p1 [DEPTH], m_p2 [DEPTH];
   logic [3:0]  m_op [DEPTH];
   logic [31:0] m_v1 [DEPTH], m_v2 [DEPTH];
   logic [7:0]  m_q1 [DEPTH], m_q2 [DEPTH];
   bit          m_ga, m_gb;
   int          m_ia, m_ib, m_sel;

   task automatic m_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_busy[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
      end
   endtask

   // Expected outputs for the current inputs, from the occupancy rules.
   task automatic model_check(input int cyc);
      int fq[$];
      int cnt;
      string p;
      p = $sformatf("rnd%0d", cyc);
      fq = {};
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) fq.push_back(i);
      m_ga = 0; m_gb = 0; m_ia = 0; m_ib = 0;
      if (!reset) begin
         if (alloc_req_A && fq.size() > 0) begin m_ga = 1; m_ia = fq.pop_front(); end
         if (alloc_req_B && (m_ga || !alloc_req_A) && fq.size() > 0) begin
            m_gb = 1; m_ib = fq.pop_front();
         end
      end
      m_sel = -1;
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_busy[i]) cnt++;
         if (m_sel < 0 && m_busy[i] && !m_p1[i] && !m_p2[i]) m_sel = i;
      end
      check_outs(p, m_ga, m_ga ? 8'(RS_ID * 8 + m_ia) : 8'd0,
                 m_gb, m_gb ? 8'(RS_ID * 8 + m_ib) : 8'd0,
                 m_sel >= 0,
                 (m_sel >= 0) ? m_op[m_sel] : 4'd0,
                 (m_sel >= 0) ? m_v1[m_sel] : 32'd0,
                 (m_sel >= 0) ? m_v2[m_sel] : 32'd0,
                 (m_sel >= 0) ? 8'(RS_ID * 8 + m_sel) : 8'd0,
                 4'(cnt));
   endtask

   task automatic m_write(input int idx, input logic [3:0] op,
                          input logic [31:0] o1, input logic t1,
                          input logic [31:0] o2, input logic t2);
      m_busy[idx] = 1; m_op[idx] = op;
      if (!t1) begin m_v1[idx] = o1; m_p1[idx] = 0; end
      else if (o1[7:0] == tag_in_CDB) begin m_v1[idx] = data_in_CDB; m_p1[idx] = 0; end
      else begin m_p1[idx] = 1; m_q1[idx] = o1[7:0]; end
      if (!t2) begin m_v2[idx] = o2; m_p2[idx] = 0; end
      else if (o2[7:0] == tag_in_CDB) begin m_v2[idx] = data_in_CDB; m_p2[idx] = 0; end
      else begin m_p2[idx] = 1; m_q2[idx] = o2[7:0]; end
   endtask

   // State after the coming rising edge.
   task automatic model_update();
      if (reset) begin
         m_clear();
         return;
      end
      if (tag_in_CDB != 8'd0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_p1[i] && m_q1[i] == tag_in_CDB) begin m_v1[i] = data_in_CDB; m_p1[i] = 0; end
            if (m_busy[i] && m_p2[i] && m_q2[i] == tag_in_CDB) begin m_v2[i] = data_in_CDB; m_p2[i] = 0; end
         end
      end
      if (m_sel >= 0 && disp_ready) begin
         $display("dispatch tag=%h op=%h a=%h b=%h", 8'(RS_ID * 8 + m_sel), m_op[m_sel], m_v1[m_sel], m_v2[m_sel]);
         m_busy[m_sel] = 0;
      end
      if (m_ga) m_write(m_ia, op_A, opnd1_A, type1_A, opnd2_A, type2_A);
      if (m_gb) m_write(m_ib, op_B, opnd1_B, type1_B, opnd2_B, type2_B);
   endtask

   function automatic logic [7:0] rnd_tag();
      logic [7:0] t;
      case ($urandom_range(0, 4))
         0: t = 8'h20;
         1: t = 8'h21;
         2: t = 8'h22;
         default: t = 8'(8 + $urandom_range(0, 3));
      endcase
      return t;
   endfunction

   function automatic logic [31:0] rnd_opnd(input logic typ);
      logic [31:0] r;
      r = $urandom();
      if (typ) r[7:0] = rnd_tag();
      return r;
   endfunction

   // ---------------------------------------------------------------- stimulus
   initial begin
      // Reset with both ports requesting: no grants while reset is high.
      idle(1, 0, 0, 0);
      drive(1, 1, 1, 3, 1, 2, 0, 0, 5, 3, 4, 0, 0, 0, 0, 0);
      chk("rst0.gnt_A", 32'(alloc_gnt_A), 0);
      chk("rst0.gnt_B", 32'(alloc_gnt_B), 0);
      chk("rst0.tag_A", 32'(tag_A), 0);
      drive(1, 1, 1, 3, 1, 2, 0, 0, 5, 3, 4, 0, 0, 0, 0, 0);
      check_outs("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      $display("reset sequence checked");

      //  rst ra rb t1 o1       o2  ct     cd        rdy ga ta     gb tb     dv op da        db      dt     bc
      add(0, 1, 0, 0, 5,       7,  0,     0,        0,  1, 8'h08, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 5,        7,      8'h08, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 5,        7,      8'h08, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      // pending operand resolved by a later broadcast
      add(0, 1, 0, 1, 32'h11,  3,  0,     0,        0,  1, 8'h08, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 1);
      add(0, 0, 0, 0, 0,       0,  8'h11, 32'hDEAD, 0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 32'hDEAD, 3,      8'h08, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 32'hDEAD, 3,      8'h08, 1);
      // same-cycle CDB bypass at allocation
      add(0, 1, 0, 1, 32'h11,  4,  8'h11, 9,        0,  1, 8'h08, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 9,        4,      8'h08, 1);
      // dual issue while entry 0 dispatches: entry 0 is not reusable yet
      add(0, 1, 1, 0, 1,       2,  0,     0,        1,  1, 8'h09, 1, 8'h0A, 1, 3, 9,        4,      8'h08, 1);
      add(0, 1, 0, 1, 32'h33,  0,  0,     0,        0,  1, 8'h08, 0, 8'h00, 1, 3, 1,        2,      8'h09, 2);
      // three busy, both request: only A; then full
      add(0, 1, 1, 0, 1,       2,  0,     0,        0,  1, 8'h0B, 0, 8'h00, 1, 3, 1,        2,      8'h09, 3);
      add(0, 1, 1, 0, 1,       2,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h09, 4);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h09, 4);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 5, 32'h100,  32'h200, 8'h0A, 3);
      // stalled on entry 3 until lower entry 0 becomes ready
      add(0, 0, 0, 0, 0,       0,  8'h33, 32'h77,   0,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h0B, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 32'h77,   0,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 32'h77,   0,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h0B, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      // dual issue into empty bank, three stall cycles
      add(0, 1, 1, 0, 1,       2,  0,     0,        0,  1, 8'h08, 1, 8'h09, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 3, 1,        2,      8'h08, 2);
      add(0, 0, 0, 0, 0,       0,  0,     0,        1,  0, 8'h00, 0, 8'h00, 1, 5, 32'h100,  32'h200, 8'h09, 1);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      // reset mid-operation with three pending entries
      add(0, 1, 0, 1, 32'h44,  1,  0,     0,        0,  1, 8'h08, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 1, 0, 1, 32'h45,  1,  0,     0,        0,  1, 8'h09, 0, 8'h00, 0, 0, 0,        0,      8'h00, 1);
      add(0, 1, 0, 1, 32'h46,  1,  0,     0,        0,  1, 8'h0A, 0, 8'h00, 0, 0, 0,        0,      8'h00, 2);
      add(1, 1, 1, 1, 32'h47,  1,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 3);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  8'h44, 5,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);
      add(0, 0, 0, 0, 0,       0,  0,     0,        0,  0, 8'h00, 0, 8'h00, 0, 0, 0,        0,      8'h00, 0);

      for (int k = 0; k < tbl.size(); k++) begin
         vec_t v;
         v = tbl[k];
         drive(v.rst, v.ra, v.rb, 4'h3, v.o1, v.o2, v.t1, 1'b0,
               4'h5, 32'h100, 32'h200, 1'b0, 1'b0, v.ct, v.cd, v.rdy);
         check_outs($sformatf("v%0d", k), v.ga, v.ta, v.gb, v.tb, v.dv, v.dop, v.da, v.db, v.dt, v.bc);
         $display("vec %0d: gntA=%b tagA=%h gntB=%b tagB=%h dv=%b dtag=%h bc=%0d",
                  k, alloc_gnt_A, tag_A, alloc_gnt_B, tag_B, disp_valid, disp_tag, busy_count);
      end

      // Both operands waiting on one tag; an unrelated tag must do nothing.
      drive(0, 1, 0, 3, 32'h50, 32'h50, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check_outs("h1", 1, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 8'h51, 1, 1);
      check_outs("h2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 8'h50, 32'h1234, 1);
      check_outs("h3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 0, 0, 1);
      check_outs("h4", 0, 0, 0, 0, 1, 3, 32'h1234, 32'h1234, 8'h08, 1);
      $display("hand seq: double pending resolved, dtag=%h a=%h b=%h", disp_tag, disp_a, disp_b);
      // B alone takes the lowest free index.
      drive(0, 0, 1, 0, 0, 0, 0, 0, 5, 32'h100, 32'h200, 0, 0, 0, 0, 0);
      check_outs("h5", 0, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0);
      idle(0, 0, 0, 1);
      check_outs("h6", 0, 0, 0, 0, 1, 5, 32'h100, 32'h200, 8'h08, 1);
      idle(0, 0, 0, 0);
      check_outs("h7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      $display("hand seq: B-only grant tagB=08 dispatched");

      // Randomized traffic against the model.
      idle(1, 0, 0, 0);
      m_clear();
      for (int c = 0; c < 3000; c++) begin
         logic rst, ra, rb, t1a, t2a, t1b, t2b, rdy;
         logic [7:0] ct;
         rst = ($urandom_range(0, 249) == 0);
         ra  = ($urandom_range(0, 2) != 0);
         rb  = ($urandom_range(0, 2) != 0);
         t1a = $urandom_range(0, 1); t2a = $urandom_range(0, 1);
         t1b = $urandom_range(0, 1); t2b = $urandom_range(0, 1);
         ct  = ($urandom_range(0, 1) != 0) ? rnd_tag() : 8'd0;
         rdy = ($urandom_range(0, 2) != 0);
         drive(rst, ra, rb, 4'($urandom_range(0, 15)), rnd_opnd(t1a), rnd_opnd(t2a), t1a, t2a,
               4'($urandom_range(0, 15)), rnd_opnd(t1b), rnd_opnd(t2b), t1b, t2b,
               ct, $urandom(), rdy);
         model_check(c);
         model_update();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
